// File: rtl/data_mem_responder.sv
// data_mem_responder
// Multi-cycle, word-organised data memory serving the MIPS memory stage.
// A request is accepted in IDLE, waits LATENCY cycles in BUSY, performs the
// access on the last BUSY edge and presents a one-cycle response in DONE.
// Optional feature macro: MISALIGN_TRAP_EN (suppresses misaligned accesses
// and flags them on rsp_err). Default build: macro undefined, rsp_err = 0.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [15:0] test_value
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          count_r;
    logic [3:0]          count_next_s;
    logic                accept_s;
    logic                access_s;
    logic                trap_s;

    logic                we_r;
    logic [ADDR_W-1:0]   index_r;
    logic [31:0]         wdata_r;
    logic [3:0]          be_r;

    logic [31:0]         mem_r [DEPTH];

    // Word index uses only req_addr[ADDR_W+1:2]; the remaining bits are
    // deliberately ignored (index wraps modulo DEPTH).
    logic                addr_unused_s;
    assign addr_unused_s = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    // Merge new store bytes over the old word under the byte enables.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Next-state, wait-state counter and accept/access strobes.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    count_next_s = LAT_M1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (count_r == 4'd0) begin
                    access_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    count_next_s = count_r - 4'd1;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                count_next_s = 4'd0;
            end
        endcase
    end

    // State and wait-state counter registers; reset aborts any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            count_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // Latch the request at acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r    <= 1'b0;
            index_r <= '0;
            wdata_r <= 32'd0;
            be_r    <= 4'd0;
        end else if (accept_s) begin
            we_r    <= req_we;
            index_r <= req_addr[ADDR_W+1:2];
            wdata_r <= req_wdata;
            be_r    <= req_be;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_r;

    // Capture the misalignment of the accepted address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_r <= 1'b0;
        end else if (accept_s) begin
            misalign_r <= (req_addr[1:0] != 2'b00);
        end
    end

    assign trap_s = misalign_r;

    // Error flag accompanies the response strobe of a trapped access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= access_s & misalign_r;
        end
    end
`else
    assign trap_s  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Registered response strobe and load data (loads only update rdata).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= access_s;
            if (access_s && !we_r && !trap_s) begin
                rsp_rdata <= mem_r[index_r];
            end
        end
    end

    // Memory array: cleared on reset, byte-masked store on the access edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (access_s && we_r && !trap_s) begin
            mem_r[index_r] <= merge_bytes(mem_r[index_r], wdata_r, be_r);
        end
    end

    assign req_ready  = (state_r == IDLE);
    assign stall      = (state_r == BUSY) | ((state_r == IDLE) & req_valid);
    assign test_value = mem_r[0][15:0];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters).
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic [15:0] test_value;

    int n_checks;
    int n_fail;

    data_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .stall      (stall),
        .test_value (test_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access; called at a negedge, returns at a negedge in IDLE.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output logic [31:0] rdata, output logic err);
        int cyc;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_hs: ready=%b stall=%b, required ready=1 stall=1", req_ready, stall);
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after acceptance; the latched request must win.
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'h0BAD_0BAD;
        req_be    = 4'hF;
        req_we    = ~we;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            n_checks++;
            if (stall !== 1'b1 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_hs: stall=%b ready=%b, required stall=1 ready=0", stall, req_ready);
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL latency: rsp_valid after %0d cycles, required 3", cyc);
        end
        n_checks++;
        if (stall !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hs: stall=%b ready=%b, required stall=0 ready=0", stall, req_ready);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL one_shot: rsp_valid=%b ready=%b, required 0 and 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 ||
            test_value !== 16'd0 || req_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b rdata=%h err=%b tv=%h ready=%b stall=%b, required 0 0 0 0 1 0",
                     rsp_valid, rsp_rdata, rsp_err, test_value, req_ready, stall);
        end
        reset = 1'b1;
        @(negedge clk);
        // Start a store to 0x4 and abort it with reset while BUSY.
        req_we    = 1'b1;
        req_addr  = 32'h4;
        req_wdata = 32'h1234_5678;
        req_be    = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy: stall=%b, required 1", stall);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b stall=%b, required 1 0", req_ready, stall);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_abort: ready=%b stall=%b valid=%b, required 1 0 0", req_ready, stall, rsp_valid);
        end
        do_access(1'b0, 32'h4, 32'd0, 4'h0, rd, er);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL aborted_store: mem[1]=%h, required 00000000", rd);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        do_access(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, rd, er);
        n_checks++;
        if (test_value !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL test_value: got %h, required beef", test_value);
        end
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL store_keeps_rdata: got %h, required 00000000", rd);
        end
        do_access(1'b0, 32'h0, 32'd0, 4'h0, rd, er);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL load_0: rdata=%h err=%b, required deadbeef 0", rd, er);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd;
        logic        er;
        do_access(1'b1, 32'h8, 32'h1122_3344, 4'hF, rd, er);
        do_access(1'b1, 32'h8, 32'h0000_00AA, 4'b0001, rd, er);
        do_access(1'b0, 32'h8, 32'd0, 4'h0, rd, er);
        n_checks++;
        if (rd !== 32'h1122_33AA) begin
            n_fail++;
            $display("FAIL byte_store: got %h, required 112233aa", rd);
        end
        do_access(1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000, rd, er);
        n_checks++;
        if (rd !== 32'h1122_33AA) begin
            n_fail++;
            $display("FAIL store_rdata_hold: got %h, required 112233aa", rd);
        end
        do_access(1'b1, 32'h8, 32'h5500_0000, 4'b1000, rd, er);
        do_access(1'b0, 32'h8, 32'd0, 4'h0, rd, er);
        n_checks++;
        if (rd !== 32'h5522_33AA) begin
            n_fail++;
            $display("FAIL be_noop_and_top: got %h, required 552233aa", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic        er;
        do_access(1'b0, 32'h100, 32'd0, 4'h0, rd, er);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wrap_0x100: got %h, required deadbeef", rd);
        end
        do_access(1'b0, 32'hFFFF_FF08, 32'd0, 4'h0, rd, er);
        n_checks++;
        if (rd !== 32'h5522_33AA) begin
            n_fail++;
            $display("FAIL wrap_upper: got %h, required 552233aa", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_word;
        logic        exp_err;
`ifdef MISALIGN_TRAP_EN
        exp_word = 32'h5566_7788;
        exp_err  = 1'b1;
`else
        exp_word = 32'hCAFE_F00D;
        exp_err  = 1'b0;
`endif
        do_access(1'b1, 32'h4, 32'h5566_7788, 4'hF, rd, er);
        do_access(1'b1, 32'h6, 32'hCAFE_F00D, 4'hF, rd, er);
        n_checks++;
        if (er !== exp_err) begin
            n_fail++;
            $display("FAIL misalign_err: rsp_err=%b, required %b", er, exp_err);
        end
        do_access(1'b0, 32'h4, 32'd0, 4'h0, rd, er);
        n_checks++;
        if (rd !== exp_word || er !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_mem: got %h err=%b, required %h 0", rd, er, exp_word);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        int nresp;
        int last;
        int nready;
        addrs[0] = 32'h0;  exps[0] = 32'hDEAD_BEEF;
        addrs[1] = 32'h8;  exps[1] = 32'h5522_33AA;
        addrs[2] = 32'h4;
`ifdef MISALIGN_TRAP_EN
        exps[2] = 32'h5566_7788;
`else
        exps[2] = 32'hCAFE_F00D;
`endif
        nresp  = 0;
        last   = 0;
        nready = 0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = addrs[0];
        req_valid = 1'b1;
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            #1;
            if (req_ready === 1'b1) nready++;
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (stall !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== exps[nresp]) begin
                    n_fail++;
                    $display("FAIL b2b_resp%0d: stall=%b ready=%b rdata=%h, required 0 0 %h",
                             nresp, stall, req_ready, rsp_rdata, exps[nresp]);
                end
                if (nresp > 0) begin
                    n_checks++;
                    if (c - last != 4) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: %0d cycles, required 4", c - last);
                    end
                end
                last = c;
                nresp++;
                if (nresp < 3) req_addr = addrs[nresp];
                else req_valid = 1'b0;
            end else begin
                n_checks++;
                if (stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_stall: cycle %0d stall=%b, required 1", c, stall);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (nresp != 3 || nready != 3) begin
            n_fail++;
            $display("FAIL b2b_count: responses=%0d ready_cycles=%0d, required 3 3", nresp, nready);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_wrap();
        test_misalign();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
